// File: rtl/uart_roi_report_tx.sv
// UART transmitter for ROI read-back. On request it snapshots (x,y,w,h) and sends an 11-byte
// 8N1 frame: two headers, four 10-bit fields as high/low byte pairs, and a mod-256 payload checksum.
module uart_roi_report_tx #(
  parameter int          CLK_FREQ = 50_000_000,
  parameter int          UART_BPS = 9600,
  parameter logic [7:0]  HEADER0  = 8'h55,
  parameter logic [7:0]  HEADER1  = 8'hAA
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       send_req,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] w,
  input  logic [9:0] h,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int             BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int             BW           = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [BW-1:0]  BAUD_LAST    = BW'(BAUD_CNT_MAX - 1);
  localparam logic [3:0]     LAST_BYTE    = 4'd10;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_n;
  logic [BW-1:0]   baud_cnt_q, baud_cnt_n;
  logic [2:0]      bit_cnt_q, bit_cnt_n;
  logic [3:0]      byte_idx_q, byte_idx_n;
  logic [9:0]      x_q, y_q, w_q, h_q;
  logic [9:0]      x_n, y_n, w_n, h_n;
  logic            tx_q, tx_n, busy_q, busy_n, done_q, done_n;
  logic [7:0]      chk, cur_byte;
  logic            bit_tick;

  assign busy     = busy_q;
  assign done     = done_q;
  assign tx       = tx_q;
  assign bit_tick = (baud_cnt_q == BAUD_LAST);

  // Checksum is taken from the latched snapshot, so it always matches the bytes on the wire.
  assign chk = {6'b0, x_q[9:8]} + x_q[7:0] + {6'b0, y_q[9:8]} + y_q[7:0]
             + {6'b0, w_q[9:8]} + w_q[7:0] + {6'b0, h_q[9:8]} + h_q[7:0];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    cur_byte = chk;
    case (byte_idx_q)
      4'd0:    cur_byte = HEADER0;
      4'd1:    cur_byte = HEADER1;
      4'd2:    cur_byte = {6'b0, x_q[9:8]};
      4'd3:    cur_byte = x_q[7:0];
      4'd4:    cur_byte = {6'b0, y_q[9:8]};
      4'd5:    cur_byte = y_q[7:0];
      4'd6:    cur_byte = {6'b0, w_q[9:8]};
      4'd7:    cur_byte = w_q[7:0];
      4'd8:    cur_byte = {6'b0, h_q[9:8]};
      4'd9:    cur_byte = h_q[7:0];
      default: cur_byte = chk;
    endcase
  end

  always_comb begin
    state_n    = state_q;
    baud_cnt_n = baud_cnt_q;
    bit_cnt_n  = bit_cnt_q;
    byte_idx_n = byte_idx_q;
    x_n        = x_q;
    y_n        = y_q;
    w_n        = w_q;
    h_n        = h_q;
    tx_n       = tx_q;
    busy_n     = busy_q;
    done_n     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (send_req) begin
          x_n        = x;
          y_n        = y;
          w_n        = w;
          h_n        = h;
          state_n    = START;
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          byte_idx_n = '0;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = DATA;
          tx_n       = cur_byte[0];
        end else begin
          baud_cnt_n = baud_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_tick) begin
          baud_cnt_n = '0;
          if (bit_cnt_q == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt_q + 1'b1;
            tx_n      = cur_byte[bit_cnt_n];
          end
        end else begin
          baud_cnt_n = baud_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          baud_cnt_n = '0;
          if (byte_idx_q == LAST_BYTE) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            tx_n    = 1'b1;
          end else begin
            byte_idx_n = byte_idx_q + 1'b1;
            state_n    = START;
            tx_n       = 1'b0;
          end
        end else begin
          baud_cnt_n = baud_cnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q    <= state_n;
      baud_cnt_q <= baud_cnt_n;
      bit_cnt_q  <= bit_cnt_n;
      byte_idx_q <= byte_idx_n;
      x_q        <= x_n;
      y_q        <= y_n;
      w_q        <= w_n;
      h_q        <= h_n;
      tx_q       <= tx_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_roi_report_tx.sv
// Directed bench for uart_roi_report_tx at 10 clocks per bit: decodes each frame from tx at
// mid-bit and checks bytes, framing, busy/done timing, busy-ignore, back-to-back and async reset.
module tb_uart_roi_report_tx;

  localparam int BIT_CLKS   = 10;
  localparam int FRAME_CLKS = 110 * BIT_CLKS;

  typedef logic [7:0] frame_t [11];

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       send_req = 1'b0;
  logic [9:0] x = '0, y = '0, w = '0, h = '0;
  logic       busy, done, tx;

  int n_tests = 0;
  int n_fail  = 0;

  uart_roi_report_tx #(
    .CLK_FREQ(1000),
    .UART_BPS(100)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .send_req(send_req),
    .x       (x),
    .y       (y),
    .w       (w),
    .h       (h),
    .busy    (busy),
    .done    (done),
    .tx      (tx)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t model(input logic [9:0] xv, yv, wv, hv);
    frame_t f;
    int     sum;
    f[0] = 8'h55;            f[1] = 8'hAA;
    f[2] = {6'b0, xv[9:8]};  f[3] = xv[7:0];
    f[4] = {6'b0, yv[9:8]};  f[5] = yv[7:0];
    f[6] = {6'b0, wv[9:8]};  f[7] = wv[7:0];
    f[8] = {6'b0, hv[9:8]};  f[9] = hv[7:0];
    sum = 0;
    for (int i = 2; i < 10; i++) sum += int'(f[i]);
    f[10] = 8'(sum % 256);
    return f;
  endfunction

  // Drives a request; with in_done_cycle the request is raised right now (inside the done cycle).
  task automatic accept(input bit in_done_cycle, input logic [9:0] xv, yv, wv, hv, input string tag);
    if (!in_done_cycle) @(negedge sys_clk);
    x = xv; y = yv; w = wv; h = hv;
    send_req = 1'b1;
    @(posedge sys_clk);
    #1;
    send_req = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    check({tag, "_start_bit"}, 32'(tx), 32'd0);
  endtask

  // Samples the whole frame from the accept edge; optionally injects a request with a new x mid-frame.
  task automatic recv(input frame_t exp, input int inject_at, input logic [9:0] inj_x, input string tag);
    logic [7:0] got_b [11];
    int frame_err, done_seen, busy_low, n, bt, k;
    frame_err = 0; done_seen = 0; busy_low = 0;
    for (int i = 0; i < 11; i++) got_b[i] = '0;
    for (int m = 0; m < FRAME_CLKS; m++) begin
      @(negedge sys_clk);
      if (done) done_seen++;
      if (!busy) busy_low++;
      if (m == inject_at) begin
        x = inj_x;
        send_req = 1'b1;
      end
      if (m == inject_at + 1) send_req = 1'b0;
      if (m % BIT_CLKS == 4) begin
        n  = m / BIT_CLKS;
        bt = n / 10;
        k  = n % 10;
        if (k == 0) begin
          if (tx !== 1'b0) frame_err++;
        end else if (k == 9) begin
          if (tx !== 1'b1) frame_err++;
        end else begin
          got_b[bt][k-1] = tx;
        end
      end
    end
    for (int i = 0; i < 11; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_b[i]), 32'(exp[i]));
    check({tag, "_framing"}, 32'(frame_err), 32'd0);
    check({tag, "_done_early"}, 32'(done_seen), 32'd0);
    check({tag, "_busy_drop"}, 32'(busy_low), 32'd0);
    @(posedge sys_clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd1);
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check({tag, "_tx_idle"}, 32'(tx), 32'd1);
  endtask

  initial begin
    frame_t f_basic, f_wrap;
    int errs;

    f_basic = '{8'h55, 8'hAA, 8'h00, 8'h64, 8'h00, 8'h32, 8'h02, 8'h80, 8'h01, 8'h68, 8'h81};
    f_wrap  = '{8'h55, 8'hAA, 8'h03, 8'hFF, 8'h03, 8'hFF, 8'h03, 8'hFF, 8'h03, 8'hFF, 8'h08};

    // 1: held in reset, requests have no effect
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      send_req = ~send_req;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) errs++;
    end
    send_req = 1'b0;
    check("rst_hold", 32'(errs), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // 2: basic frame against the hand-computed byte list
    accept(1'b0, 10'd100, 10'd50, 10'd640, 10'd360, "basic");
    recv(f_basic, -1, '0, "basic");
    @(posedge sys_clk); #1;
    check("basic_done_one_cycle", 32'(done), 32'd0);

    // 3: checksum wrap
    repeat (3) @(negedge sys_clk);
    accept(1'b0, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, "wrap");
    recv(f_wrap, -1, '0, "wrap");

    // 4: request while busy is dropped; frame keeps the first snapshot
    repeat (3) @(negedge sys_clk);
    accept(1'b0, 10'd5, 10'd300, 10'd17, 10'd1023, "ignore");
    recv(model(10'd5, 10'd300, 10'd17, 10'd1023), 300, 10'd999, "ignore");
    @(posedge sys_clk); #1;
    check("ignore_done_one_cycle", 32'(done), 32'd0);
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (busy !== 1'b0 || done !== 1'b0 || tx !== 1'b1) errs++;
    end
    check("ignore_no_queued_frame", 32'(errs), 32'd0);

    // 5: back-to-back, second request raised in the done cycle
    accept(1'b0, 10'd1, 10'd2, 10'd3, 10'd4, "b2b_a");
    recv(model(10'd1, 10'd2, 10'd3, 10'd4), -1, '0, "b2b_a");
    accept(1'b1, 10'd513, 10'd258, 10'd771, 10'd129, "b2b_b");
    recv(model(10'd513, 10'd258, 10'd771, 10'd129), -1, '0, "b2b_b");

    // 6: async reset mid-frame, then a fresh frame
    repeat (3) @(negedge sys_clk);
    accept(1'b0, 10'd100, 10'd50, 10'd640, 10'd360, "midrst");
    repeat (450) @(negedge sys_clk);
    check("midrst_pre_tx", 32'(tx), 32'd0);
    #2;
    sys_rst = 1'b1;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      if (busy !== 1'b0 || done !== 1'b0 || tx !== 1'b1) errs++;
    end
    check("midrst_no_resume", 32'(errs), 32'd0);
    accept(1'b0, 10'd77, 10'd600, 10'd1000, 10'd3, "fresh");
    recv(model(10'd77, 10'd600, 10'd1000, 10'd3), -1, '0, "fresh");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
